regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters.
//  req0 is the ALU writeback; req1 is the load/long-latency unit.
//  Each requester has its own small FIFO. A round-robin arbiter drains the FIFOs into a registered issue stage.
//  Pending-write lookups let the decode stage stall on RAW hazards against queued writes.
// PARAMETERS
//  DATA_W   32  write data width
//  ADDR_W   5   register address width
//  DEPTH    2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst_n      in   1       synchronous reset, active-low
//  req0_valid in   1       ALU write request
//  req0_ready out  1       FIFO0 not full
//  req0_addr  in   ADDR_W  destination register
//  req0_data  in   DATA_W  write data
//  req1_valid in   1       load-unit write request
//  req1_ready out  1       FIFO1 not full
//  req1_addr  in   ADDR_W  destination register
//  req1_data  in   DATA_W  write data
//  rf_we3     out  1       register-file write enable (registered)
//  rf_a3      out  ADDR_W  register-file write address (registered)
//  rf_wd3     out  DATA_W  register-file write data (registered)
//  chk_a1     in   ADDR_W  decode read address 1
//  chk_a2     in   ADDR_W  decode read address 2
//  pend1      out  1       a write to chk_a1 is queued or issuing
//  pend2      out  1       a write to chk_a2 is queued or issuing
//  busy       out  1       any FIFO non-empty, or rf_we3 high
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge):
//    - Flushes both FIFOs; queued writes are lost, including on a mid-operation reset.
//    - rf_we3=0, rf_a3=0, rf_wd3=0; round-robin pointer favours req0.
//    - reqN_ready=0 while rst_n=0.
//  - Handshake: accept when reqN_valid & reqN_ready at the edge.
//    - ready = !full only; no pass-through. A full FIFO stays not-ready even in a cycle it pops.
//  - Address 0: accepted (handshake completes) but never enqueued; x0 is never written.
//  - Arbitration each cycle, over the FIFO heads:
//    - One head non-empty: that head is granted.
//    - Both non-empty: grant the requester not granted last. The pointer updates only on a grant.
//    - Exception: both heads target the same address. Grant req0 first regardless of pointer, so req1's data is final.
//  - Issue: at the grant edge the head is popped into the issue register; rf_we3=1 the following cycle.
//    - rf_we3=0 in any cycle with no grant at the previous edge.
//  - Latency: accept at edge t -> rf_we3 high in cycle t+2 (empty FIFO, no competition) -> register written at edge t+2.
//  - Throughput: one write per cycle total. Per-requester order is preserved.
//  - Hazard lookup (combinational): pendK=1 iff chk_aK!=0 and the address matches either:
//    - any valid entry in either FIFO, or
//    - the issue register while rf_we3=1.
//  - Simultaneous push and pop on the same FIFO: both happen; occupancy is unchanged.
//  - Pointer wrap: FIFO pointers are log2(DEPTH)+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.
// STRUCTURE
//  - Package rf_pkg: DATA_W/ADDR_W defaults, localparam X0_ADDR='0, typedef rf_wr_t {addr, data}.
//  - Sub-module rf_wr_fifo: DEPTH-entry synchronous FIFO of rf_wr_t, instantiated twice. It exposes:
//    - push, pop, full, empty, head;
//    - an entry-valid vector plus the entry array, for the hazard compare.
//  - Top level contains the arbiter, the issue register and the hazard compare.
// TESTING
//  1. Reset flush: enqueue req0 to x5 and x6, assert rst_n=0 for 1 cycle.
//     -> no rf_we3 ever for those writes; busy=0 after reset.
//  2. Single write: req0 {addr=3, data=0xDEADBEEF} at edge t.
//     -> cycle t+2: rf_we3=1, rf_a3=3, rf_wd3=0xDEADBEEF. rf_we3=0 at t+3.
//  3. x0 discard: req1 {addr=0, data=0x1234} with req1_ready=1.
//     -> handshake completes; rf_we3 stays 0; pend1=0 for chk_a1=0.
//  4. Round-robin: both requesters stream 4 writes (req0 to x1..x4, req1 to x11..x14).
//     -> rf_a3 sequence 1,11,2,12,3,13,4,14, one per cycle; no gaps.
//  5. Same-address collision: both heads target x7 (req0 0xA, req1 0xB), pointer favouring req1.
//     -> x7 gets 0xA, then 0xB on the next cycle.
//  6. Backpressure + hazard: hold req1 blocked by a continuous req0 stream; fill FIFO1 with DEPTH=2 entries to x9.
//     -> req1_ready=0 while full.
//     -> with chk_a2=9: pend2=1 until the cycle after the last x9 write, then 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    // Writes to this register are accepted but dropped; x0 is hard-wired zero.
    localparam logic [RF_ADDR_W-1:0] X0_ADDR = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// DEPTH-entry synchronous FIFO of pending register writes. The whole entry array and a
// per-slot valid vector are exported so the top level can search queued writes for hazards.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = rf_wr_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output entry_t           head,
    output logic [DEPTH-1:0] vld,
    output entry_t           entries [DEPTH]
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] count;
    entry_t        mem_q [DEPTH];

    // Pointer update; the extra MSB distinguishes full from empty after a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Entry storage; contents are don't-care until marked valid by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign head    = mem_q[rd_ptr_q[IW-1:0]];
    assign count   = wr_ptr_q - rd_ptr_q;
    assign entries = mem_q;

    // Slot i holds a live entry when its distance from the read slot is below the occupancy.
    always_comb begin
        vld = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [IW-1:0] off;
            off    = IW'(i) - rd_ptr_q[IW-1:0];
            vld[i] = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU (req0) and the load unit
// (req1). Each requester has its own FIFO; a round-robin arbiter drains the heads into a
// registered issue stage, and the decode stage can query queued/issuing writes for RAW hazards.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    input  logic [ADDR_W-1:0] chk_a1,
    input  logic [ADDR_W-1:0] chk_a2,
    output logic              pend1,
    output logic              pend2,
    output logic              busy
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic             full0, empty0, full1, empty1;
    logic             push0, push1;
    logic             gnt0, gnt1;
    logic             fav1_q, fav1_d;
    wr_t              head0, head1;
    logic [DEPTH-1:0] vld0, vld1;
    wr_t              ent0 [DEPTH];
    wr_t              ent1 [DEPTH];

    // No pass-through: a full FIFO refuses even when it pops this cycle.
    assign req0_ready = rst_n & ~full0;
    assign req1_ready = rst_n & ~full1;

    // Writes to x0 complete the handshake but are never queued.
    assign push0 = req0_valid & req0_ready & (req0_addr != ADDR_W'(X0_ADDR));
    assign push1 = req1_valid & req1_ready & (req1_addr != ADDR_W'(X0_ADDR));

    rf_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wr_t)
    ) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push0),
        .wdata   ({req0_addr, req0_data}),
        .pop     (gnt0),
        .full    (full0),
        .empty   (empty0),
        .head    (head0),
        .vld     (vld0),
        .entries (ent0)
    );

    rf_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wr_t)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push1),
        .wdata   ({req1_addr, req1_data}),
        .pop     (gnt1),
        .full    (full1),
        .empty   (empty1),
        .head    (head1),
        .vld     (vld1),
        .entries (ent1)
    );

    // Round-robin grant; equal head addresses force req0 first so req1's value lands last.
    always_comb begin
        logic same_addr;
        same_addr = !empty0 && !empty1 && (head0.addr == head1.addr);
        gnt0      = !empty0 && (empty1 || same_addr || !fav1_q);
        gnt1      = !empty1 && !gnt0;
        fav1_d    = fav1_q;
        if (gnt0) fav1_d = 1'b1;
        if (gnt1) fav1_d = 1'b0;
    end

    // Round-robin pointer: set means req1 is favoured on the next contention.
    always_ff @(posedge clk) begin
        if (!rst_n) fav1_q <= 1'b0;
        else        fav1_q <= fav1_d;
    end

    // Issue register driving the register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we3 <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else begin
            rf_we3 <= gnt0 | gnt1;
            if (gnt0) begin
                rf_a3  <= head0.addr;
                rf_wd3 <= head0.data;
            end else if (gnt1) begin
                rf_a3  <= head1.addr;
                rf_wd3 <= head1.data;
            end
        end
    end

    // Hazard lookup across both FIFOs and the issuing write; x0 never reports pending.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld0[i] && ent0[i].addr == chk_a1) pend1 = 1'b1;
            if (vld1[i] && ent1[i].addr == chk_a1) pend1 = 1'b1;
            if (vld0[i] && ent0[i].addr == chk_a2) pend2 = 1'b1;
            if (vld1[i] && ent1[i].addr == chk_a2) pend2 = 1'b1;
        end
        if (rf_we3 && rf_a3 == chk_a1) pend1 = 1'b1;
        if (rf_we3 && rf_a3 == chk_a2) pend2 = 1'b1;
        if (chk_a1 == ADDR_W'(X0_ADDR)) pend1 = 1'b0;
        if (chk_a2 == ADDR_W'(X0_ADDR)) pend2 = 1'b0;
    end

    // Activity flag: anything queued or a write on the port this cycle.
    assign busy = !empty0 || !empty1 || rf_we3;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model plus directed literal checks.
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          rf_we3;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;
    logic [AW-1:0] chk_a1, chk_a2;
    logic          pend1, pend2, busy;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_we3     (rf_we3),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3),
        .chk_a1     (chk_a1),
        .chk_a2     (chk_a2),
        .pend1      (pend1),
        .pend2      (pend2),
        .busy       (busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_s;

    // Reference model state
    wr_s           q0[$];
    wr_s           q1[$];
    bit            m_fav1;
    bit            m_we;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_wd;
    bit            m_known = 1'b0;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [AW-1:0] a3_log[$];
    int            we_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_pend(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        foreach (q0[i]) if (q0[i].addr == a) return 1'b1;
        foreach (q1[i]) if (q1[i].addr == a) return 1'b1;
        if (m_we && m_a == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare();
        check("req0_ready", req0_ready, 32'(rst_n && q0.size() < DEPTH));
        check("req1_ready", req1_ready, 32'(rst_n && q1.size() < DEPTH));
        check("rf_we3", rf_we3, 32'(m_we));
        if (m_we) begin
            check("rf_a3", 32'(rf_a3), 32'(m_a));
            check("rf_wd3", rf_wd3, m_wd);
        end
        check("pend1", pend1, 32'(m_pend(chk_a1)));
        check("pend2", pend2, 32'(m_pend(chk_a2)));
        check("busy", busy, 32'(q0.size() > 0 || q1.size() > 0 || m_we));
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_edge();
        bit  acc0, acc1, g0, g1;
        wr_s e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_fav1 = 1'b0;
            m_we   = 1'b0;
            m_a    = '0;
            m_wd   = '0;
            return;
        end
        acc0 = req0_valid && q0.size() < DEPTH;
        acc1 = req1_valid && q1.size() < DEPTH;
        g0 = 1'b0;
        g1 = 1'b0;
        if (q0.size() > 0 && q1.size() > 0) begin
            if (q0[0].addr == q1[0].addr) g0 = 1'b1;
            else if (m_fav1)              g1 = 1'b1;
            else                          g0 = 1'b1;
        end else if (q0.size() > 0) g0 = 1'b1;
        else if (q1.size() > 0)     g1 = 1'b1;
        m_we = g0 || g1;
        if (g0) begin
            e = q0.pop_front();
            m_a = e.addr; m_wd = e.data; m_fav1 = 1'b1;
        end
        if (g1) begin
            e = q1.pop_front();
            m_a = e.addr; m_wd = e.data; m_fav1 = 1'b0;
        end
        if (acc0 && req0_addr != 0) q0.push_back('{req0_addr, req0_data});
        if (acc1 && req1_addr != 0) q1.push_back('{req1_addr, req1_data});
    endtask

    // Inputs are set at the falling edge; compare, step model, and return at the next falling edge.
    task automatic step();
        #1;
        if (m_known) compare();
        model_edge();
        m_known = 1'b1;
        @(negedge clk);
        cyc++;
        if (rf_we3) begin
            a3_log.push_back(rf_a3);
            we_cyc.push_back(cyc);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a3_log.delete();
        we_cyc.delete();
    endtask

    initial begin
        int i0, i1;
        logic [AW-1:0] exp4 [8];
        exp4 = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        idle();
        chk_a1 = '0;
        chk_a2 = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_we", rf_we3, 0);
        check("rst_a3", 32'(rf_a3), 0);
        check("rst_wd3", rf_wd3, 0);
        check("rst_busy", busy, 0);

        // 1. Reset flushes a queued write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h5555;
        step();
        req0_addr = 5'd6; req0_data = 32'h6666;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        check("flush_busy", busy, 0);
        a3_log.delete();
        repeat (4) step();
        check("flush_no_write", a3_log.size(), 0);

        // 2. Single write latency
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        step();
        idle();
        check("single_t1_we", rf_we3, 0);
        step();
        check("single_t2_we", rf_we3, 1);
        check("single_t2_a3", 32'(rf_a3), 3);
        check("single_t2_wd3", rf_wd3, 32'hDEADBEEF);
        step();
        check("single_t3_we", rf_we3, 0);

        // 3. x0 write is accepted and dropped
        a3_log.delete();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        chk_a1 = '0;
        #1;
        check("x0_ready", req1_ready, 1);
        step();
        idle();
        check("x0_pend1", pend1, 0);
        repeat (3) step();
        check("x0_no_write", a3_log.size(), 0);

        // 4. Round-robin streaming
        do_reset();
        i0 = 0; i1 = 0;
        for (int c = 0; c < 20; c++) begin
            bit a0, a1;
            req0_valid = (i0 < 4); req0_addr = AW'(i0 + 1);  req0_data = $urandom;
            req1_valid = (i1 < 4); req1_addr = AW'(i1 + 11); req1_data = $urandom;
            a0 = req0_valid && q0.size() < DEPTH;
            a1 = req1_valid && q1.size() < DEPTH;
            step();
            if (a0) i0++;
            if (a1) i1++;
        end
        idle();
        check("rr_count", a3_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < a3_log.size()) check("rr_seq", 32'(a3_log[k]), 32'(exp4[k]));
        end
        if (we_cyc.size() == 8) check("rr_no_gap", we_cyc[7] - we_cyc[0], 7);

        // 5. Same-address collision with pointer favouring req1
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'h1;
        step();
        idle();
        repeat (2) step();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
        step();
        idle();
        step();
        check("coll_first_we", rf_we3, 1);
        check("coll_first_a3", 32'(rf_a3), 7);
        check("coll_first_wd3", rf_wd3, 32'hA);
        step();
        check("coll_second_we", rf_we3, 1);
        check("coll_second_a3", 32'(rf_a3), 7);
        check("coll_second_wd3", rf_wd3, 32'hB);

        // 6. Backpressure and hazard on x9
        do_reset();
        chk_a2 = 5'd9;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hC1;
        step();
        req0_addr = 5'd2; req0_data = 32'h200;
        req1_data = 32'hC2;
        step();
        req1_valid = 1'b0;
        #1;
        check("bp_ready1", req1_ready, 0);
        check("bp_pend2", pend2, 1);
        for (int c = 0; c < 10; c++) begin
            req0_addr = AW'(1 + (c % 4));
            req0_data = $urandom;
            step();
        end
        idle();
        repeat (6) step();
        check("bp_pend2_clear", pend2, 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            req0_valid = $urandom_range(0, 1);
            req0_addr  = AW'($urandom_range(0, 7));
            req0_data  = $urandom;
            req1_valid = $urandom_range(0, 1);
            req1_addr  = AW'($urandom_range(0, 7));
            req1_data  = $urandom;
            chk_a1     = AW'($urandom_range(0, 9));
            chk_a2     = AW'($urandom_range(0, 9));
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (4) step();
        #1;
        compare();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
